// File: rtl/iic_pkg.sv
// rtl/iic_pkg.sv - shared state encoding, direction constants and width helper for the iic arbiter
package iic_pkg;

  typedef enum logic [2:0] {
    IDLE,
    LAUNCH,
    WAIT_BUSY,
    WAIT_DONE,
    RESP
  } iic_state_t;

  localparam logic WR = 1'b0;
  localparam logic RD = 1'b1;

  // Ceiling log2 with a floor of 1 so single-value ranges still get a bit.
  function automatic int clog2(input int value);
    int w;
    w = 1;
    while ((1 << w) < value) w++;
    return w;
  endfunction

endpackage

// File: rtl/iic_rr_pick.sv
// rtl/iic_rr_pick.sv - rotate-priority encoder: first set request scanning upward from last+1
module iic_rr_pick #(
  parameter int NREQ = 4,
  parameter int IW   = 2
) (
  input  logic [NREQ-1:0] req,
  input  logic [IW-1:0]   last,
  output logic [NREQ-1:0] gnt_next,
  output logic [IW-1:0]   index,
  output logic            any
);

  int pos;

  always_comb begin
    gnt_next = '0;
    index    = '0;
    any      = 1'b0;
    pos      = 0;
    for (int i = 1; i <= NREQ; i++) begin
      pos = (int'(last) + i) % NREQ;
      if (!any && req[pos]) begin
        any           = 1'b1;
        index         = IW'(pos);
        gnt_next[pos] = 1'b1;
      end
    end
  end

endmodule

// File: rtl/iic_arbiter.sv
// rtl/iic_arbiter.sv - round-robin arbiter and sequencer sharing one iic byte engine between requesters
module iic_arbiter
  import iic_pkg::*;
#(
  parameter int NREQ     = 4,
  parameter int START_TO = 16,
  parameter int BUSY_TO  = 4096
) (
  input  logic              clk_i,
  input  logic              rst,
  input  logic [NREQ-1:0]   req,
  input  logic [NREQ-1:0]   req_wr_rd,
  input  logic [8*NREQ-1:0] req_dev_addr,
  input  logic [16*NREQ-1:0] req_register,
  input  logic [8*NREQ-1:0] req_data,
  output logic [NREQ-1:0]   gnt,
  output logic [NREQ-1:0]   done,
  output logic              done_err,
  output logic [7:0]        done_rd_data,
  output logic              start_en,
  output logic              wr_rd_flag,
  output logic [7:0]        i2c_device_addr,
  output logic [15:0]       register,
  output logic [7:0]        data_byte,
  input  logic              busy,
  input  logic              err,
  input  logic [7:0]        rd_data
);

  localparam int IW = clog2(NREQ);
  localparam int CW = clog2((START_TO > BUSY_TO) ? START_TO : BUSY_TO);
  localparam logic [CW-1:0] START_LAST = CW'(START_TO - 1);
  localparam logic [CW-1:0] BUSY_LAST  = CW'(BUSY_TO - 1);

  iic_state_t      state, state_next;
  logic [IW-1:0]   last, winner, pick_index;
  logic [NREQ-1:0] pick_gnt;
  logic            pick_any;
  logic [CW-1:0]   cnt;
  logic            timeout, cap_err;
  logic [7:0]      cap_rd;
  logic            sel_rd;
  logic [7:0]      sel_dev, sel_data;
  logic [15:0]     sel_reg;

  iic_rr_pick #(.NREQ(NREQ), .IW(IW)) u_pick (
    .req      (req),
    .last     (last),
    .gnt_next (pick_gnt),
    .index    (pick_index),
    .any      (pick_any)
  );

  always_comb begin
    sel_rd   = 1'b0;
    sel_dev  = '0;
    sel_reg  = '0;
    sel_data = '0;
    for (int k = 0; k < NREQ; k++) begin
      if (pick_gnt[k]) begin
        sel_rd   = req_wr_rd[k];
        sel_dev  = req_dev_addr[8*k +: 8];
        sel_reg  = req_register[16*k +: 16];
        sel_data = req_data[8*k +: 8];
      end
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst) state <= IDLE;
    else     state <= state_next;
  end

  always_comb begin
    state_next = state;
    case (state)
      IDLE:      if (pick_any) state_next = LAUNCH;
      LAUNCH:    state_next = WAIT_BUSY;
      WAIT_BUSY: begin
        if (busy)                   state_next = WAIT_DONE;
        else if (cnt == START_LAST) state_next = RESP;
      end
      WAIT_DONE: if (!busy || cnt == BUSY_LAST) state_next = RESP;
      RESP:      state_next = IDLE;
      default:   state_next = IDLE;
    endcase
  end

  // Latched fields only load in IDLE, so they stay frozen for the whole grant.
  always_ff @(posedge clk_i) begin
    if (rst) begin
      gnt             <= '0;
      done            <= '0;
      done_err        <= 1'b0;
      done_rd_data    <= '0;
      start_en        <= 1'b0;
      wr_rd_flag      <= 1'b0;
      i2c_device_addr <= '0;
      register        <= '0;
      data_byte       <= '0;
      last            <= IW'(NREQ - 1);
      winner          <= '0;
      cnt             <= '0;
      timeout         <= 1'b0;
      cap_err         <= 1'b0;
      cap_rd          <= '0;
    end else begin
      start_en <= 1'b0;
      done     <= '0;
      case (state)
        IDLE: begin
          if (pick_any) begin
            gnt             <= pick_gnt;
            winner          <= pick_index;
            wr_rd_flag      <= sel_rd;
            i2c_device_addr <= sel_dev;
            register        <= sel_reg;
            data_byte       <= sel_data;
            timeout         <= 1'b0;
            cap_err         <= 1'b0;
          end
        end
        LAUNCH: begin
          start_en <= 1'b1;
          cnt      <= '0;
        end
        WAIT_BUSY: begin
          if (busy)                   cnt     <= '0;
          else if (cnt == START_LAST) timeout <= 1'b1;
          else                        cnt     <= cnt + 1'b1;
        end
        WAIT_DONE: begin
          if (!busy) begin
            cap_err <= err;
            cap_rd  <= rd_data;
          end else if (cnt == BUSY_LAST) begin
            timeout <= 1'b1;
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
        RESP: begin
          done     <= gnt;
          done_err <= cap_err | timeout;
          if (!timeout) done_rd_data <= cap_rd;
          last     <= winner;
          gnt      <= '0;
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_iic_arbiter.sv
// tb/tb_iic_arbiter.sv - self-checking bench for iic_arbiter with engine model and round-robin reference
module tb_iic_arbiter;

  localparam int NREQ     = 4;
  localparam int START_TO = 16;
  localparam int BUSY_TO  = 4096;

  logic                 clk_i = 1'b0;
  logic                 rst   = 1'b1;
  logic [NREQ-1:0]      req   = '0;
  logic [NREQ-1:0]      req_wr_rd;
  logic [8*NREQ-1:0]    req_dev_addr;
  logic [16*NREQ-1:0]   req_register;
  logic [8*NREQ-1:0]    req_data;
  logic [NREQ-1:0]      gnt, done;
  logic                 done_err, start_en, wr_rd_flag;
  logic [7:0]           done_rd_data, i2c_device_addr, data_byte;
  logic [15:0]          register;
  logic                 busy = 1'b0, err = 1'b0;
  logic [7:0]           rd_data = '0;

  logic       f_rd[NREQ];
  logic [7:0] f_dev[NREQ], f_data[NREQ];
  logic [15:0] f_reg[NREQ];

  always #5 clk_i = ~clk_i;

  always_comb begin
    for (int k = 0; k < NREQ; k++) begin
      req_wr_rd[k]            = f_rd[k];
      req_dev_addr[8*k +: 8]  = f_dev[k];
      req_register[16*k +: 16] = f_reg[k];
      req_data[8*k +: 8]      = f_data[k];
    end
  end

  iic_arbiter #(.NREQ(NREQ), .START_TO(START_TO), .BUSY_TO(BUSY_TO)) dut (
    .clk_i           (clk_i),
    .rst             (rst),
    .req             (req),
    .req_wr_rd       (req_wr_rd),
    .req_dev_addr    (req_dev_addr),
    .req_register    (req_register),
    .req_data        (req_data),
    .gnt             (gnt),
    .done            (done),
    .done_err        (done_err),
    .done_rd_data    (done_rd_data),
    .start_en        (start_en),
    .wr_rd_flag      (wr_rd_flag),
    .i2c_device_addr (i2c_device_addr),
    .register        (register),
    .data_byte       (data_byte),
    .busy            (busy),
    .err             (err),
    .rd_data         (rd_data)
  );

  int n_checks = 0;
  int n_errors = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  // Reference round-robin: build the priority order starting after the last winner.
  function automatic int model_pick(input logic [NREQ-1:0] r, input int last_idx);
    int order[$];
    for (int i = 0; i < NREQ; i++) order.push_back((last_idx + 1 + i) % NREQ);
    foreach (order[j]) if (r[order[j]]) return order[j];
    return -1;
  endfunction

  int          last_m = NREQ - 1;
  bit          in_tx = 0;
  int          exp_idx, tx_cycles, starts;
  logic [7:0]  exp_rd = '0;
  logic        e_rd;
  logic [31:0] e_fields;
  logic [NREQ-1:0] done_seen;

  // Engine model: 0 normal, 1 busy never rises, 2 busy stuck high.
  bit          use_rand = 0;
  int          dir_mode = 0, dir_dur = 4;
  bit          dir_nack = 0;
  logic [7:0]  dir_val = '0;
  int          tx_mode, tx_dur, eng_st = 0, eng_wait;
  bit          tx_nack;
  logic [7:0]  tx_val;

  task automatic mon();
    int idx;
    @(negedge clk_i);
    if (rst) begin
      in_tx = 0; last_m = NREQ - 1; exp_rd = '0; eng_st = 0;
      busy = 1'b0; err = 1'b0; rd_data = '0; done_seen = '0;
      check("rst_gnt", gnt, 0);
      check("rst_done", done, 0);
      check("rst_start", start_en, 0);
      check("rst_done_err", done_err, 0);
      check("rst_rd_data", done_rd_data, 0);
      check("rst_fields", {wr_rd_flag, i2c_device_addr, register, data_byte}, 0);
      return;
    end
    done_seen = done;
    if (in_tx) begin
      tx_cycles++;
      if (start_en) begin
        starts++;
        if (starts == 1) check("start_lat", tx_cycles, 2);
      end
      if (gnt == '0) begin
        check("done", done, 1 << exp_idx);
        check("done_err", done_err, (tx_mode != 0) ? 1'b1 : tx_nack);
        if (tx_mode == 0) exp_rd = tx_val;
        check("done_rd_data", done_rd_data, exp_rd);
        check("start_count", starts, 1);
        if (tx_mode == 1) check("to_start_lat", tx_cycles, START_TO + 3);
        if (tx_mode == 2) check("to_busy_lat", tx_cycles, BUSY_TO + 6);
        if (tx_mode == 2) begin busy = 1'b0; eng_st = 0; end
        last_m = exp_idx;
        in_tx  = 0;
      end else begin
        check("gnt_hold", gnt, 1 << exp_idx);
        check("fields_hold", {i2c_device_addr, register, data_byte}, e_fields);
        check("wr_rd_hold", wr_rd_flag, e_rd);
        check("done_in_tx", done, 0);
      end
    end else if (gnt != '0) begin
      idx = model_pick(req, last_m);
      check("gnt", gnt, (idx < 0) ? 0 : (1 << idx));
      if (idx < 0) idx = 0;
      exp_idx  = idx;
      e_rd     = f_rd[idx];
      e_fields = {f_dev[idx], f_reg[idx], f_data[idx]};
      check("fields", {i2c_device_addr, register, data_byte}, e_fields);
      check("wr_rd", wr_rd_flag, e_rd);
      check("done_at_gnt", done, 0);
      check("start_at_gnt", start_en, 0);
      in_tx = 1; tx_cycles = 1; starts = 0;
    end else begin
      check("idle_done", done, 0);
      check("idle_start", start_en, 0);
    end

    err = 1'b0;
    case (eng_st)
      0: if (start_en) begin
        if (use_rand) begin
          tx_mode = ($urandom_range(0, 99) < 85) ? 0 : 1;
          tx_dur  = $urandom_range(1, 12);
          tx_nack = ($urandom_range(0, 3) == 0);
          tx_val  = 8'($urandom);
        end else begin
          tx_mode = dir_mode; tx_dur = dir_dur; tx_nack = dir_nack; tx_val = dir_val;
        end
        if (tx_mode != 1) begin eng_st = 1; eng_wait = 2; end
      end
      1: begin
        eng_wait--;
        if (eng_wait == 0) begin busy = 1'b1; eng_wait = tx_dur; eng_st = 2; end
      end
      2: if (tx_mode == 0) begin
        eng_wait--;
        if (eng_wait == 0) begin
          busy = 1'b0; err = tx_nack; rd_data = tx_val; eng_st = 0;
        end
      end
      default: eng_st = 0;
    endcase
  endtask

  task automatic wait_done(input string tag, input int bound);
    int n = 0;
    done_seen = '0;
    while (done_seen == '0 && n < bound) begin
      mon();
      n++;
    end
    check(tag, (done_seen == '0), 0);
  endtask

  task automatic do_reset();
    rst = 1'b1;
    mon();
    rst = 1'b0;
    req = '0;
  endtask

  task automatic set_fields(input int k);
    f_rd[k]   = 1'($urandom);
    f_dev[k]  = 8'($urandom);
    f_reg[k]  = 16'($urandom);
    f_data[k] = 8'($urandom);
  endtask

  int order_q[$];

  initial begin
    for (int k = 0; k < NREQ; k++) set_fields(k);
    mon();
    mon();
    rst = 1'b0;

    // Single write from requester 0, engine busy for 200 cycles.
    f_rd[0] = iic_pkg::WR; f_dev[0] = 8'h78; f_reg[0] = 16'h3008; f_data[0] = 8'h82;
    dir_mode = 0; dir_dur = 200; dir_nack = 0; dir_val = 8'h11;
    req = 4'b0001;
    wait_done("wr_wait", 400);
    req = '0;
    check("wr_done", done_seen, 4'b0001);
    check("wr_err", done_err, 0);

    // Read from requester 2.
    f_rd[2] = iic_pkg::RD;
    dir_dur = 5; dir_val = 8'h5A;
    req = 4'b0100;
    wait_done("rd_wait", 100);
    req = '0;
    check("rd_done", done_seen, 4'b0100);
    check("rd_data", done_rd_data, 8'h5A);

    // Contention from a fresh reset: order must be 0,1,2,3,0.
    do_reset();
    dir_dur = 3;
    req = 4'b1111;
    for (int t = 0; t < 5; t++) begin
      wait_done("cont_wait", 100);
      for (int k = 0; k < NREQ; k++) if (done_seen[k]) order_q.push_back(k);
    end
    req = '0;
    check("cont_len", order_q.size(), 5);
    for (int t = 0; t < 5 && t < order_q.size(); t++)
      check("cont_order", order_q[t], (t == 4) ? 0 : t);

    // NACK then a clean follow-up.
    dir_nack = 1; dir_val = 8'h33;
    req = 4'b0010;
    wait_done("nack_wait", 100);
    req = '0;
    check("nack_err", done_err, 1);
    dir_nack = 0; dir_val = 8'hC4;
    req = 4'b0001;
    wait_done("after_nack_wait", 100);
    req = '0;
    check("after_nack_err", done_err, 0);

    // Busy never rises, then busy stuck high.
    dir_mode = 1;
    req = 4'b1000;
    wait_done("to_start_wait", 100);
    req = '0;
    check("to_start_err", done_err, 1);
    dir_mode = 2;
    req = 4'b0001;
    wait_done("to_busy_wait", BUSY_TO + 100);
    req = '0;
    check("to_busy_err", done_err, 1);

    // Reset during WAIT_DONE abandons the transfer and restores the pointer.
    dir_mode = 0; dir_dur = 200;
    req = 4'b0100;
    for (int n = 0; n < 10; n++) mon();
    check("mid_busy", busy, 1);
    do_reset();
    mon();
    check("post_rst_done", done, 0);
    dir_dur = 4;
    req = 4'b1001;
    wait_done("ptr_wait", 100);
    req = '0;
    check("ptr_reset", done_seen, 4'b0001);

    // Requester 1 drops req mid-transaction; done still fires.
    req = 4'b0010;
    for (int n = 0; n < 4; n++) mon();
    req[1] = 1'b0;
    wait_done("drop_wait", 100);
    check("drop_done", done_seen, 4'b0010);

    // Randomised traffic against the reference model.
    use_rand = 1;
    for (int c = 0; c < 6000; c++) begin
      mon();
      for (int k = 0; k < NREQ; k++) begin
        if (done_seen[k]) begin
          if ($urandom_range(0, 1) == 0) req[k] = 1'b0;
          else set_fields(k);
        end else if (!req[k] && $urandom_range(0, 5) == 0) begin
          set_fields(k);
          req[k] = 1'b1;
        end
      end
    end
    for (int c = 0; c < 2000 && (req != '0 || in_tx); c++) begin
      mon();
      for (int k = 0; k < NREQ; k++) if (done_seen[k]) req[k] = 1'b0;
    end
    check("drain", {req != '0, in_tx}, 0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
